// File: rtl/bus_lsu_master.sv
// Load/store bus master: turns one CPU request into a single word-aligned bus
// transaction. Optional misalignment trap is enabled by defining BUS_ALIGN_CHECK_EN.
module bus_lsu_master #(
  parameter int unsigned MIN_LATENCY    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        store_q, store_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [31:0] wdata_rep;
  logic [3:0]  be_calc;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_done;
  logic        bus_timeout;

  // Lane replication and byte enables come straight from the incoming request.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wdata_rep = req_wdata;
    be_calc   = 4'b1111;
    case (req_size)
      2'b00: begin
        wdata_rep = {4{req_wdata[7:0]}};
        be_calc   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_rep = {2{req_wdata[15:0]}};
        be_calc   = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

`ifdef BUS_ALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    lane      = readdata;
    load_data = readdata;
    case (size_q)
      2'b00: begin
        lane      = readdata >> {addr_lo_q, 3'b000};
        load_data = signed_q ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      end
      2'b01: begin
        lane      = readdata >> {addr_lo_q[1], 4'b0000};
        load_data = signed_q ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
      end
      default: ;
    endcase
  end

  // waitrequest=0 is meaningless until the memory has had MIN_LATENCY cycles to raise it.
  assign bus_done    = (wait_cnt_q >= MIN_LATENCY) && !waitrequest;
  assign bus_timeout = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    signed_d     = signed_q;
    store_d      = store_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_lo_d    = req_addr[1:0];
          size_d       = req_size;
          signed_d     = req_signed;
          store_d      = req_write;
          address_d    = {req_addr[31:2], 2'b00};
          writedata_d  = wdata_rep;
          byteenable_d = be_calc;
          wait_cnt_d   = '0;
          if (misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = ST_RESP;
          end else begin
            rd_d    = !req_write;
            wr_d    = req_write;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 32'd1;
        // Completion wins over a timeout landing on the same edge.
        if (bus_done) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = store_q ? 32'b0 : load_data;
          state_d      = ST_RESP;
        end else if (bus_timeout) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      addr_lo_q    <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      store_q      <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign read       = rd_q;
  assign write      = wr_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
